// File: rtl/freq_monitor_supervisor.sv
// freq_monitor_supervisor
//
// Once per measurement window, checks each lane's kHz tally against a
// programmable inclusive [min,max] window. Lane lock (lane_ok) is qualified
// with hysteresis, and a sticky irq is raised when any enabled lane changes
// lock state.
//
// Build option: define FREQ_MON_SUPERVISOR_HISTORY_EN to add per-lane
// min/max snapshot history returned on the read port.
//
// Ports:
//   ref_clk, rst      clock, synchronous active-high reset
//   khz_counters      lane i count at [20i+19:20i]
//   window_tick       one-cycle pulse that starts a scan (ignored if busy)
//   cfg_wr/cfg_lane/cfg_min/cfg_max   per-lane threshold write
//   rd_req/rd_lane    read request; rd_ack/rd_data answer one cycle later
//   rd_data           {lane_ok, last_in_range, snapshot count[19:0]}
//   lane_ok           qualified per-lane lock status
//   irq, irq_clr      sticky change interrupt and its clear
//   tick_overrun      sticky; tick arrived while a scan was running
//   dbg_state         FSM state (0=IDLE, 1=SCAN, 2=DONE)
//   rd_hist_min/max   (history build only) lane snapshot extremes
//
// Handshake: rd_req is a single-cycle request that is always accepted;
// rd_ack pulses exactly one cycle later with rd_data valid in that cycle.
// Requests may be issued on every cycle.
module freq_monitor_supervisor #(
  parameter int NUM_SIGNALS  = 4,
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic                      ref_clk,
  input  logic                      rst,
  input  logic [20*NUM_SIGNALS-1:0] khz_counters,
  input  logic                      window_tick,
  input  logic                      cfg_wr,
  input  logic [3:0]                cfg_lane,
  input  logic [19:0]               cfg_min,
  input  logic [19:0]               cfg_max,
  input  logic                      rd_req,
  input  logic [3:0]                rd_lane,
  output logic                      rd_ack,
  output logic [21:0]               rd_data,
  output logic [NUM_SIGNALS-1:0]    lane_ok,
  output logic                      irq,
  input  logic                      irq_clr,
  output logic                      tick_overrun,
  output logic [1:0]                dbg_state
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
  ,
  output logic [19:0]               rd_hist_min,
  output logic [19:0]               rd_hist_max
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             scan_idx;
  logic [19:0]            snap     [NUM_SIGNALS];
  logic [19:0]            min_r    [NUM_SIGNALS];
  logic [19:0]            max_r    [NUM_SIGNALS];
  logic [3:0]             good_cnt [NUM_SIGNALS];
  logic [3:0]             bad_cnt  [NUM_SIGNALS];
  logic [NUM_SIGNALS-1:0] last_in_range;
  logic [NUM_SIGNALS-1:0] prev_ok;

`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
  logic [19:0]            hist_min [NUM_SIGNALS];
  logic [19:0]            hist_max [NUM_SIGNALS];
  logic [19:0]            rd_sel_hmin;
  logic [19:0]            rd_sel_hmax;
`endif

  // Per-lane combinational evaluation terms
  logic [NUM_SIGNALS-1:0] lane_en;
  logic [NUM_SIGNALS-1:0] in_rng;
  logic [NUM_SIGNALS-1:0] eval_hit;
  logic [NUM_SIGNALS-1:0] cfg_hit;
  logic [3:0]             good_inc [NUM_SIGNALS];
  logic [3:0]             bad_inc  [NUM_SIGNALS];
  logic [21:0]            rd_sel_data;
  logic                   ok_changed;

  assign dbg_state = state;

  always_comb begin
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      lane_en[i]  = (min_r[i] <= max_r[i]);
      in_rng[i]   = lane_en[i] && (snap[i] >= min_r[i]) && (snap[i] <= max_r[i]);
      good_inc[i] = (good_cnt[i] == 4'hF) ? 4'hF : good_cnt[i] + 4'd1;
      bad_inc[i]  = (bad_cnt[i] == 4'hF) ? 4'hF : bad_cnt[i] + 4'd1;
      eval_hit[i] = (state == SCAN) && (scan_idx == 4'(i));
      cfg_hit[i]  = cfg_wr && (cfg_lane == 4'(i));
    end
  end

  // Only lanes that are enabled now may raise irq on a lock change.
  assign ok_changed = |((lane_ok ^ prev_ok) & lane_en);

  // Read mux: out-of-range lane indices fall through to zero.
  always_comb begin
    rd_sel_data = '0;
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
    rd_sel_hmin = '0;
    rd_sel_hmax = '0;
`endif
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (rd_lane == 4'(i)) begin
        rd_sel_data = {lane_ok[i], last_in_range[i], snap[i]};
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
        rd_sel_hmin = hist_min[i];
        rd_sel_hmax = hist_max[i];
`endif
      end
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state         <= IDLE;
      scan_idx      <= '0;
      irq           <= 1'b0;
      tick_overrun  <= 1'b0;
      rd_ack        <= 1'b0;
      rd_data       <= '0;
      lane_ok       <= '0;
      prev_ok       <= '0;
      last_in_range <= '0;
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
      rd_hist_min   <= '0;
      rd_hist_max   <= '0;
`endif
      for (int i = 0; i < NUM_SIGNALS; i++) begin
        snap[i]     <= '0;
        min_r[i]    <= '0;
        max_r[i]    <= '0;
        good_cnt[i] <= '0;
        bad_cnt[i]  <= '0;
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
        hist_min[i] <= 20'hFFFFF;
        hist_max[i] <= '0;
`endif
      end
    end else begin
      // Read port
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data <= rd_sel_data;
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
        rd_hist_min <= rd_sel_hmin;
        rd_hist_max <= rd_sel_hmax;
`endif
      end

      // Sticky flags: set wins over clear
      if (window_tick && (state != IDLE))
        tick_overrun <= 1'b1;
      else if (irq_clr)
        tick_overrun <= 1'b0;

      if ((state == DONE) && ok_changed)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;

      // FSM
      case (state)
        IDLE: begin
          if (window_tick) begin
            state    <= SCAN;
            scan_idx <= '0;
            prev_ok  <= lane_ok;
          end
        end
        SCAN: begin
          if (scan_idx == 4'(NUM_SIGNALS - 1))
            state <= DONE;
          else
            scan_idx <= scan_idx + 4'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Per-lane state. A config write on a lane discards any evaluation of
      // that lane in the same cycle, and also clears its pre-scan lock copy
      // so the forced clear cannot show up as an irq-worthy change.
      for (int i = 0; i < NUM_SIGNALS; i++) begin
        if ((state == IDLE) && window_tick)
          snap[i] <= khz_counters[20*i +: 20];

        if (cfg_hit[i]) begin
          min_r[i]         <= cfg_min;
          max_r[i]         <= cfg_max;
          good_cnt[i]      <= '0;
          bad_cnt[i]       <= '0;
          lane_ok[i]       <= 1'b0;
          last_in_range[i] <= 1'b0;
          prev_ok[i]       <= 1'b0;
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
          hist_min[i]      <= 20'hFFFFF;
          hist_max[i]      <= '0;
`endif
        end else if (eval_hit[i]) begin
          if (!lane_en[i]) begin
            good_cnt[i]      <= '0;
            bad_cnt[i]       <= '0;
            lane_ok[i]       <= 1'b0;
            last_in_range[i] <= 1'b0;
          end else begin
            last_in_range[i] <= in_rng[i];
            if (in_rng[i]) begin
              good_cnt[i] <= good_inc[i];
              bad_cnt[i]  <= '0;
              if (good_inc[i] >= 4'(LOCK_COUNT))
                lane_ok[i] <= 1'b1;
            end else begin
              bad_cnt[i]  <= bad_inc[i];
              good_cnt[i] <= '0;
              if (bad_inc[i] >= 4'(UNLOCK_COUNT))
                lane_ok[i] <= 1'b0;
            end
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
            if (snap[i] < hist_min[i]) hist_min[i] <= snap[i];
            if (snap[i] > hist_max[i]) hist_max[i] <= snap[i];
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_monitor_supervisor.sv
// Directed bench for freq_monitor_supervisor with NUM_SIGNALS=4,
// LOCK_COUNT=3, UNLOCK_COUNT=2.
module tb_freq_monitor_supervisor;

  localparam int N = 4;

  logic          ref_clk = 1'b0;
  logic          rst;
  logic [20*N-1:0] khz_counters;
  logic          window_tick;
  logic          cfg_wr;
  logic [3:0]    cfg_lane;
  logic [19:0]   cfg_min;
  logic [19:0]   cfg_max;
  logic          rd_req;
  logic [3:0]    rd_lane;
  logic          rd_ack;
  logic [21:0]   rd_data;
  logic [N-1:0]  lane_ok;
  logic          irq;
  logic          irq_clr;
  logic          tick_overrun;
  logic [1:0]    dbg_state;
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
  logic [19:0]   rd_hist_min;
  logic [19:0]   rd_hist_max;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] exp_q[$];

  freq_monitor_supervisor #(
    .NUM_SIGNALS (N),
    .LOCK_COUNT  (3),
    .UNLOCK_COUNT(2)
  ) dut (
    .ref_clk     (ref_clk),
    .rst         (rst),
    .khz_counters(khz_counters),
    .window_tick (window_tick),
    .cfg_wr      (cfg_wr),
    .cfg_lane    (cfg_lane),
    .cfg_min     (cfg_min),
    .cfg_max     (cfg_max),
    .rd_req      (rd_req),
    .rd_lane     (rd_lane),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .lane_ok     (lane_ok),
    .irq         (irq),
    .irq_clr     (irq_clr),
    .tick_overrun(tick_overrun),
`ifdef FREQ_MON_SUPERVISOR_HISTORY_EN
    .rd_hist_min (rd_hist_min),
    .rd_hist_max (rd_hist_max),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 ref_clk = ~ref_clk;

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set_counts(input logic [19:0] c0, input logic [19:0] c1,
                            input logic [19:0] c2, input logic [19:0] c3);
    khz_counters = {c3, c2, c1, c0};
  endtask

  task automatic cfg(input logic [3:0] lane, input logic [19:0] mn, input logic [19:0] mx);
    cfg_wr = 1'b1; cfg_lane = lane; cfg_min = mn; cfg_max = mx;
    step();
    cfg_wr = 1'b0;
  endtask

  // Tick plus the full scan: returns just after the DONE edge.
  task automatic window();
    window_tick = 1'b1;
    step();
    window_tick = 1'b0;
    repeat (N + 1) step();
  endtask

  task automatic pulse_irq_clr();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  // Single read; expected value goes through the scoreboard queue.
  task automatic read_lane(input string tag, input logic [3:0] lane, input logic [21:0] exp);
    exp_q.push_back(exp);
    rd_req = 1'b1; rd_lane = lane;
    step();
    rd_req = 1'b0;
    check({tag, "_ack"}, 64'(rd_ack), 64'd1);
    check(tag, 64'(rd_data), 64'(exp_q.pop_front()));
  endtask

  initial begin
    rst = 1'b1; window_tick = 0; cfg_wr = 0; cfg_lane = 0; cfg_min = 0; cfg_max = 0;
    rd_req = 0; rd_lane = 0; irq_clr = 0; khz_counters = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_lane_ok", 64'(lane_ok), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_overrun", 64'(tick_overrun), 64'd0);
    check("rst_ack", 64'(rd_ack), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // Lane0 window, lanes 1/3 disabled, lane2 disabled with min>max
    cfg(4'd0, 20'd156000, 20'd156500);
    cfg(4'd1, 20'd1, 20'd0);
    cfg(4'd2, 20'd10, 20'd5);
    cfg(4'd3, 20'd1, 20'd0);
    set_counts(20'd156250, 20'd7, 20'd7, 20'd7);
    window();
    check("w1_ok", 64'(lane_ok), 64'd0);
    window();
    check("w2_ok", 64'(lane_ok), 64'd0);
    check("w2_irq", 64'(irq), 64'd0);
    // Third window: lane_ok rises at tick+1, irq only on the DONE edge (tick+5)
    window_tick = 1'b1;
    step();
    window_tick = 1'b0;
    step();
    check("w3_ok_early", 64'(lane_ok), 64'b0001);
    repeat (3) step();
    check("w3_irq_pre_done", 64'(irq), 64'd0);
    step();
    check("w3_irq_done", 64'(irq), 64'd1);
    check("w3_ok", 64'(lane_ok), 64'b0001);
    pulse_irq_clr();
    check("irq_cleared", 64'(irq), 64'd0);
    read_lane("rd_l0_lock", 4'd0, {1'b1, 1'b1, 20'd156250});
    read_lane("rd_l2_dis", 4'd2, {1'b0, 1'b0, 20'd7});

    // One bad window then a good one: lock holds
    set_counts(20'd0, 20'd7, 20'd7, 20'd7);
    window();
    check("bad1_ok", 64'(lane_ok), 64'b0001);
    set_counts(20'd156250, 20'd7, 20'd7, 20'd7);
    window();
    check("good_after_bad_ok", 64'(lane_ok), 64'b0001);
    check("good_after_bad_irq", 64'(irq), 64'd0);

    // Two bad windows: unlock and irq again
    set_counts(20'd0, 20'd7, 20'd7, 20'd7);
    window();
    check("unlock1_ok", 64'(lane_ok), 64'b0001);
    window();
    check("unlock2_ok", 64'(lane_ok), 64'b0000);
    check("unlock2_irq", 64'(irq), 64'd1);
    check("lane2_never_ok", 64'(lane_ok[2]), 64'd0);
    pulse_irq_clr();

    // Boundaries: lane0 min==max=100, lane1 [100,200]
    cfg(4'd0, 20'd100, 20'd100);
    cfg(4'd1, 20'd100, 20'd200);
    set_counts(20'd100, 20'd100, 20'd7, 20'd7);
    window();
    read_lane("bnd_eq", 4'd0, {1'b0, 1'b1, 20'd100});
    read_lane("bnd_min", 4'd1, {1'b0, 1'b1, 20'd100});
    set_counts(20'd101, 20'd200, 20'd7, 20'd7);
    window();
    read_lane("bnd_above", 4'd0, {1'b0, 1'b0, 20'd101});
    read_lane("bnd_max", 4'd1, {1'b0, 1'b1, 20'd200});
    check("bnd_irq", 64'(irq), 64'd0);

    // Tick overrun at tick+2
    cfg(4'd1, 20'd1, 20'd0);
    set_counts(20'd101, 20'd555, 20'd7, 20'd7);
    window_tick = 1'b1;
    step();
    window_tick = 1'b0;
    step();
    window_tick = 1'b1;
    step();
    window_tick = 1'b0;
    check("overrun_set", 64'(tick_overrun), 64'd1);
    repeat (3) step();
    step();
    check("overrun_idle", 64'(dbg_state), 64'd0);
    pulse_irq_clr();
    check("overrun_clr", 64'(tick_overrun), 64'd0);

    // Relock lane0; irq_clr coincident with the DONE set: set wins
    set_counts(20'd100, 20'd555, 20'd7, 20'd7);
    window();
    window();
    check("relock_pre_ok", 64'(lane_ok), 64'd0);
    window_tick = 1'b1;
    step();
    window_tick = 1'b0;
    repeat (N) step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("set_wins_irq", 64'(irq), 64'd1);
    check("relock_ok", 64'(lane_ok), 64'b0001);
    pulse_irq_clr();

    // Back-to-back reads for lanes 0, 1, 7
    exp_q.push_back({1'b1, 1'b1, 20'd100});
    exp_q.push_back({1'b0, 1'b0, 20'd555});
    exp_q.push_back(22'h0);
    rd_req = 1'b1; rd_lane = 4'd0;
    step();
    check("b2b0_ack", 64'(rd_ack), 64'd1);
    check("b2b0_data", 64'(rd_data), 64'(exp_q.pop_front()));
    rd_lane = 4'd1;
    step();
    check("b2b1_ack", 64'(rd_ack), 64'd1);
    check("b2b1_data", 64'(rd_data), 64'(exp_q.pop_front()));
    rd_lane = 4'd7;
    step();
    check("b2b7_ack", 64'(rd_ack), 64'd1);
    check("b2b7_data", 64'(rd_data), 64'(exp_q.pop_front()));
    rd_req = 1'b0;
    step();
    check("b2b_ack_drop", 64'(rd_ack), 64'd0);

    // Reset mid-scan
    window_tick = 1'b1;
    step();
    window_tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ok", 64'(lane_ok), 64'd0);
    check("mid_rst_irq", 64'(irq), 64'd0);
    check("mid_rst_overrun", 64'(tick_overrun), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    read_lane("mid_rst_snap", 4'd0, 22'h0);

    // Fresh scans from reset config (min=max=0): count 0 locks all lanes
    set_counts(20'd0, 20'd0, 20'd0, 20'd0);
    window();
    window();
    check("fresh2_ok", 64'(lane_ok), 64'd0);
    window();
    check("fresh3_ok", 64'(lane_ok), 64'hF);
    check("fresh3_irq", 64'(irq), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
